// File: rtl/alu_hs_if.sv
// Command/result handshake bundle for alu_hs_seq: producer drives the command side,
// consumer drives out_ready; the ALU itself uses the slave modport.
interface alu_hs_if #(
  parameter int WIDTH = 8
);
  logic                 in_valid;
  logic                 in_ready;
  logic [WIDTH-1:0]     in_a;
  logic [WIDTH-1:0]     in_b;
  logic [1:0]           in_op;
  logic                 out_valid;
  logic                 out_ready;
  logic [2*WIDTH-1:0]   out_result;
  logic                 out_err;

  modport master (
    output in_valid, in_a, in_b, in_op, out_ready,
    input  in_ready, out_valid, out_result, out_err
  );

  modport slave (
    input  in_valid, in_a, in_b, in_op, out_ready,
    output in_ready, out_valid, out_result, out_err
  );
endinterface

// File: rtl/alu_hs_seq.sv
// WIDTH-bit unsigned add/sub/mul/div with valid/ready on both sides.
// Division uses a restoring divider producing one quotient bit per cycle, MSB first.
module alu_hs_seq #(
  parameter int WIDTH = 8
) (
  input  logic     clk,
  input  logic     reset,
  alu_hs_if.slave  bus
);

  localparam int CW = $clog2(WIDTH + 1);

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_MUL = 2'b10;
  localparam logic [1:0] OP_DIV = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE,
    S_DIV,
    S_DONE
  } state_t;

  state_t             state;
  logic [WIDTH-1:0]   div_rem;
  logic [WIDTH-1:0]   div_quo;
  logic [WIDTH-1:0]   div_dsr;
  logic [CW-1:0]      div_cnt;

  logic               accept;
  logic [WIDTH:0]     sum;
  logic [WIDTH:0]     diff;
  logic [2*WIDTH-1:0] cmd_result;
  logic               cmd_err;
  logic               cmd_to_div;

  logic [WIDTH:0]     step_part;
  logic [WIDTH:0]     step_diff;
  logic               step_ge;

  // A finished result can retire and a new command enter on the same edge.
  assign bus.in_ready = (state == S_IDLE) || (state == S_DONE && bus.out_ready);
  assign accept       = bus.in_valid && bus.in_ready;

  always_comb begin
    sum        = {1'b0, bus.in_a} + {1'b0, bus.in_b};
    diff       = {1'b0, bus.in_a} - {1'b0, bus.in_b};
    cmd_result = '0;
    cmd_err    = 1'b0;
    cmd_to_div = 1'b0;
    case (bus.in_op)
      OP_ADD: cmd_result = {{(WIDTH-1){1'b0}}, sum};
      OP_SUB: cmd_result = {{(WIDTH-1){diff[WIDTH]}}, diff};
      OP_MUL: cmd_result = {{WIDTH{1'b0}}, bus.in_a} * {{WIDTH{1'b0}}, bus.in_b};
      OP_DIV: begin
        if (bus.in_b == '0) begin
          cmd_result = {bus.in_a, {WIDTH{1'b1}}};
          cmd_err    = 1'b1;
        end else begin
          cmd_to_div = 1'b1;
        end
      end
      default: cmd_result = '0;
    endcase
  end

  // The partial remainder never reaches twice the divisor, so the borrow bit
  // of the trial subtraction is exactly the "doesn't fit" indication.
  always_comb begin
    step_part = {div_rem, div_quo[WIDTH-1]};
    step_diff = step_part - {1'b0, div_dsr};
    step_ge   = ~step_diff[WIDTH];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state          <= S_IDLE;
      bus.out_valid  <= 1'b0;
      bus.out_result <= '0;
      bus.out_err    <= 1'b0;
      div_rem        <= '0;
      div_quo        <= '0;
      div_dsr        <= '0;
      div_cnt        <= '0;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          if (accept) begin
            if (cmd_to_div) begin
              state         <= S_DIV;
              bus.out_valid <= 1'b0;
              bus.out_err   <= 1'b0;
              div_rem       <= '0;
              div_quo       <= bus.in_a;
              div_dsr       <= bus.in_b;
              div_cnt       <= CW'(WIDTH);
            end else begin
              state          <= S_DONE;
              bus.out_valid  <= 1'b1;
              bus.out_result <= cmd_result;
              bus.out_err    <= cmd_err;
            end
          end else if (state == S_DONE && bus.out_ready) begin
            state         <= S_IDLE;
            bus.out_valid <= 1'b0;
          end
        end
        S_DIV: begin
          if (div_cnt == '0) begin
            state          <= S_DONE;
            bus.out_valid  <= 1'b1;
            bus.out_result <= {div_rem, div_quo};
            bus.out_err    <= 1'b0;
          end else begin
            div_rem <= step_ge ? step_diff[WIDTH-1:0] : step_part[WIDTH-1:0];
            div_quo <= {div_quo[WIDTH-2:0], step_ge};
            div_cnt <= div_cnt - 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_hs_seq.sv
// Directed bench for alu_hs_seq at WIDTH=8: each task drives one scenario and
// compares outputs against hand-computed values.
module tb_alu_hs_seq;

  localparam int WIDTH = 8;
  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_MUL = 2'b10;
  localparam logic [1:0] OP_DIV = 2'b11;

  logic clk = 1'b0;
  logic reset;
  int   n_compared   = 0;
  int   n_mismatched = 0;

  alu_hs_if #(.WIDTH(WIDTH)) bus ();

  alu_hs_seq #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Inputs change and outputs are sampled 1 time unit after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [1:0] op, input logic [7:0] a, input logic [7:0] b);
    bus.in_valid = v;
    bus.in_op    = op;
    bus.in_a     = a;
    bus.in_b     = b;
  endtask

  task automatic test_reset();
    reset         = 1'b1;
    bus.out_ready = 1'b0;
    drive(1'b0, OP_ADD, 8'd0, 8'd0);
    step();
    step();
    n_compared++;
    if (bus.out_valid !== 1'b0) begin
      n_mismatched++;
      $display("[TB] FAIL reset_out_valid: got %b expected 0", bus.out_valid);
    end
    n_compared++;
    if (bus.out_result !== 16'h0000 || bus.out_err !== 1'b0) begin
      n_mismatched++;
      $display("[TB] FAIL reset_result: got %h/%b expected 0000/0", bus.out_result, bus.out_err);
    end
    reset = 1'b0;
    step();
    n_compared++;
    if (bus.in_ready !== 1'b1) begin
      n_mismatched++;
      $display("[TB] FAIL reset_in_ready: got %b expected 1", bus.in_ready);
    end
  endtask

  task automatic test_add();
    bus.out_ready = 1'b1;
    drive(1'b1, OP_ADD, 8'd200, 8'd100);
    step();
    drive(1'b0, OP_MUL, 8'd7, 8'd7);
    n_compared++;
    if (bus.out_valid !== 1'b1 || bus.out_result !== 16'h012C || bus.out_err !== 1'b0) begin
      n_mismatched++;
      $display("[TB] FAIL add_200_100: got v=%b r=%h e=%b expected v=1 r=012C e=0",
               bus.out_valid, bus.out_result, bus.out_err);
    end
    step();
    n_compared++;
    if (bus.out_valid !== 1'b0) begin
      n_mismatched++;
      $display("[TB] FAIL add_drain: got out_valid %b expected 0", bus.out_valid);
    end
  endtask

  task automatic test_back_to_back();
    bus.out_ready = 1'b1;
    drive(1'b1, OP_SUB, 8'd5, 8'd7);
    step();
    n_compared++;
    if (bus.out_valid !== 1'b1 || bus.out_result !== 16'hFFFE || bus.out_err !== 1'b0) begin
      n_mismatched++;
      $display("[TB] FAIL sub_5_7: got v=%b r=%h e=%b expected v=1 r=FFFE e=0",
               bus.out_valid, bus.out_result, bus.out_err);
    end
    drive(1'b1, OP_MUL, 8'd255, 8'd255);
    #1;
    n_compared++;
    if (bus.in_ready !== 1'b1) begin
      n_mismatched++;
      $display("[TB] FAIL b2b_in_ready: got %b expected 1", bus.in_ready);
    end
    step();
    n_compared++;
    if (bus.out_valid !== 1'b1 || bus.out_result !== 16'hFE01 || bus.out_err !== 1'b0) begin
      n_mismatched++;
      $display("[TB] FAIL mul_255_255: got v=%b r=%h e=%b expected v=1 r=FE01 e=0",
               bus.out_valid, bus.out_result, bus.out_err);
    end
    drive(1'b0, OP_ADD, 8'd0, 8'd0);
    step();
    n_compared++;
    if (bus.out_valid !== 1'b0) begin
      n_mismatched++;
      $display("[TB] FAIL b2b_drain: got out_valid %b expected 0", bus.out_valid);
    end
  endtask

  task automatic test_div();
    int busy_errs;
    busy_errs     = 0;
    bus.out_ready = 1'b1;
    drive(1'b1, OP_DIV, 8'd100, 8'd7);
    step();
    // Scramble operands to show they were captured at accept.
    drive(1'b0, OP_ADD, 8'd3, 8'd0);
    for (int k = 0; k < 8; k++) begin
      if (bus.in_ready !== 1'b0 || bus.out_valid !== 1'b0) begin
        busy_errs++;
        $display("[TB] FAIL div_busy cycle %0d: got in_ready=%b out_valid=%b expected 0/0",
                 k + 1, bus.in_ready, bus.out_valid);
      end
      step();
    end
    n_compared++;
    if (busy_errs != 0) n_mismatched++;
    n_compared++;
    if (bus.out_valid !== 1'b0) begin
      n_mismatched++;
      $display("[TB] FAIL div_early: got out_valid %b expected 0 before cycle 9", bus.out_valid);
    end
    step();
    n_compared++;
    if (bus.out_valid !== 1'b1 || bus.out_result !== 16'h020E || bus.out_err !== 1'b0) begin
      n_mismatched++;
      $display("[TB] FAIL div_100_7: got v=%b r=%h e=%b expected v=1 r=020E e=0",
               bus.out_valid, bus.out_result, bus.out_err);
    end
    step();
    n_compared++;
    if (bus.out_valid !== 1'b0) begin
      n_mismatched++;
      $display("[TB] FAIL div_drain: got out_valid %b expected 0", bus.out_valid);
    end
  endtask

  task automatic test_div_zero();
    bus.out_ready = 1'b1;
    drive(1'b1, OP_DIV, 8'd42, 8'd0);
    step();
    drive(1'b0, OP_ADD, 8'd0, 8'd0);
    n_compared++;
    if (bus.out_valid !== 1'b1 || bus.out_result !== 16'h2AFF || bus.out_err !== 1'b1) begin
      n_mismatched++;
      $display("[TB] FAIL div_42_0: got v=%b r=%h e=%b expected v=1 r=2AFF e=1",
               bus.out_valid, bus.out_result, bus.out_err);
    end
    step();
    n_compared++;
    if (bus.out_valid !== 1'b0) begin
      n_mismatched++;
      $display("[TB] FAIL div0_drain: got out_valid %b expected 0", bus.out_valid);
    end
  endtask

  task automatic test_backpressure();
    bus.out_ready = 1'b0;
    drive(1'b1, OP_ADD, 8'd1, 8'd2);
    step();
    // This command must not be taken while the result is stalled.
    drive(1'b1, OP_MUL, 8'd9, 8'd9);
    for (int k = 0; k < 3; k++) begin
      n_compared++;
      if (bus.out_valid !== 1'b1 || bus.out_result !== 16'h0003 || bus.in_ready !== 1'b0) begin
        n_mismatched++;
        $display("[TB] FAIL stall cycle %0d: got v=%b r=%h in_ready=%b expected v=1 r=0003 in_ready=0",
                 k, bus.out_valid, bus.out_result, bus.in_ready);
      end
      step();
    end
    bus.out_ready = 1'b1;
    drive(1'b1, OP_MUL, 8'd3, 8'd4);
    #1;
    n_compared++;
    if (bus.in_ready !== 1'b1 || bus.out_result !== 16'h0003) begin
      n_mismatched++;
      $display("[TB] FAIL release_ready: got in_ready=%b r=%h expected 1/0003", bus.in_ready, bus.out_result);
    end
    step();
    drive(1'b0, OP_ADD, 8'd0, 8'd0);
    n_compared++;
    if (bus.out_valid !== 1'b1 || bus.out_result !== 16'h000C || bus.out_err !== 1'b0) begin
      n_mismatched++;
      $display("[TB] FAIL mul_3_4: got v=%b r=%h e=%b expected v=1 r=000C e=0",
               bus.out_valid, bus.out_result, bus.out_err);
    end
    step();
    n_compared++;
    if (bus.out_valid !== 1'b0) begin
      n_mismatched++;
      $display("[TB] FAIL stall_drain: got out_valid %b expected 0", bus.out_valid);
    end
  endtask

  task automatic test_reset_mid_div();
    int stray;
    stray         = 0;
    bus.out_ready = 1'b1;
    drive(1'b1, OP_DIV, 8'd200, 8'd3);
    step();
    drive(1'b0, OP_ADD, 8'd0, 8'd0);
    for (int k = 0; k < 4; k++) step();
    reset = 1'b1;
    #1;
    n_compared++;
    if (bus.out_valid !== 1'b0 || bus.out_result !== 16'h0000 || bus.out_err !== 1'b0) begin
      n_mismatched++;
      $display("[TB] FAIL async_reset: got v=%b r=%h e=%b expected 0/0000/0",
               bus.out_valid, bus.out_result, bus.out_err);
    end
    step();
    reset = 1'b0;
    for (int k = 0; k < 12; k++) begin
      step();
      if (bus.out_valid !== 1'b0) begin
        stray++;
        $display("[TB] FAIL abandoned_div cycle %0d: got out_valid %b expected 0", k, bus.out_valid);
      end
    end
    n_compared++;
    if (stray != 0) n_mismatched++;
    n_compared++;
    if (bus.in_ready !== 1'b1 || bus.out_result !== 16'h0000) begin
      n_mismatched++;
      $display("[TB] FAIL post_reset: got in_ready=%b r=%h expected 1/0000", bus.in_ready, bus.out_result);
    end
  endtask

  initial begin
    test_reset();
    test_add();
    test_back_to_back();
    test_div();
    test_div_zero();
    test_backpressure();
    test_reset_mid_div();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
